// File: rtl/csi_param_decoder.sv
// CSI escape-sequence parameter decoder: parses ESC '[' <digits/';'> <final> into
// a command with up to MAX_PARAMS saturating numeric fields, held until consumed.
module csi_param_decoder #(
  parameter int MAX_PARAMS = 2,
  parameter int PARAM_W    = 8,
  parameter int DEF_VAL    = 1
) (
  input  logic                                 clk,
  input  logic                                 _rst,
  input  logic                                 in_valid,
  input  logic [7:0]                           in,
  output logic                                 in_ready,
  output logic                                 cmd_valid,
  input  logic                                 cmd_ready,
  output logic [7:0]                           cmd_code,
  output logic [$clog2(MAX_PARAMS+1)-1:0]      cmd_nparams,
  output logic [MAX_PARAMS*PARAM_W-1:0]        cmd_params,
  output logic                                 cmd_ovf,
  output logic                                 err
);

  localparam int IDX_W = $clog2(MAX_PARAMS + 1);
  localparam int AW    = PARAM_W + 4;
  localparam logic [PARAM_W-1:0] DEF_F = PARAM_W'(DEF_VAL);
  localparam logic [AW-1:0]      SAT_W = {4'b0000, {PARAM_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, ESC, PARAM, HOLD} state_t;

  state_t               state_reg, state_next;
  logic [PARAM_W-1:0]   field_reg [MAX_PARAMS];
  logic [PARAM_W-1:0]   field_next [MAX_PARAMS];
  logic [MAX_PARAMS-1:0] filled_reg, filled_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [IDX_W-1:0]     nparams_reg, nparams_next;
  logic                 ovf_reg, ovf_next;
  logic                 seen_reg, seen_next;
  logic                 err_reg, err_next;
  logic [7:0]           code_reg, code_next;

  logic                 accept;
  logic                 is_digit;
  logic                 is_final;
  logic [AW-1:0]        acc_base;
  logic [AW-1:0]        acc_wide;

  assign in_ready = (state_reg != HOLD);
  assign accept   = in_valid && in_ready;
  assign is_digit = (in >= 8'h30) && (in <= 8'h39);
  assign is_final = (in >= 8'h40) && (in <= 8'h7E);

  always_comb begin
    state_next   = state_reg;
    field_next   = field_reg;
    filled_next  = filled_reg;
    idx_next     = idx_reg;
    nparams_next = nparams_reg;
    ovf_next     = ovf_reg;
    seen_next    = seen_reg;
    code_next    = code_reg;
    err_next     = 1'b0;
    acc_base     = '0;
    acc_wide     = '0;

    case (state_reg)
      IDLE: begin
        if (accept && in == 8'h1B) state_next = ESC;
      end
      ESC: begin
        if (accept) begin
          if (in == 8'h5B) begin
            state_next = PARAM;
            for (int i = 0; i < MAX_PARAMS; i++) field_next[i] = DEF_F;
            filled_next = '0;
            idx_next    = '0;
            ovf_next    = 1'b0;
            seen_next   = 1'b0;
          end else if (in == 8'h1B) begin
            state_next = ESC;
          end else begin
            state_next = IDLE;
            err_next   = 1'b1;
          end
        end
      end
      PARAM: begin
        if (accept) begin
          if (is_digit) begin
            seen_next = 1'b1;
            // A field's first digit replaces DEF_VAL rather than extending it.
            if (!ovf_reg) begin
              for (int i = 0; i < MAX_PARAMS; i++) begin
                if (idx_reg == IDX_W'(i)) begin
                  acc_base       = filled_reg[i] ? {4'b0000, field_reg[i]} : '0;
                  acc_wide       = acc_base * AW'(10) + AW'(in[3:0]);
                  field_next[i]  = (acc_wide > SAT_W) ? SAT_W[PARAM_W-1:0]
                                                      : acc_wide[PARAM_W-1:0];
                  filled_next[i] = 1'b1;
                end
              end
            end
          end else if (in == 8'h3B) begin
            seen_next = 1'b1;
            if (int'(idx_reg) < MAX_PARAMS - 1) idx_next = idx_reg + IDX_W'(1);
            else                                ovf_next = 1'b1;
          end else if (is_final) begin
            state_next   = HOLD;
            code_next    = in;
            nparams_next = seen_reg ? idx_reg + IDX_W'(1) : '0;
          end else if (in == 8'h1B) begin
            state_next = ESC;
            err_next   = 1'b1;
          end else begin
            state_next = IDLE;
            err_next   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cmd_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_reg   <= IDLE;
      for (int i = 0; i < MAX_PARAMS; i++) field_reg[i] <= DEF_F;
      filled_reg  <= '0;
      idx_reg     <= '0;
      nparams_reg <= '0;
      ovf_reg     <= 1'b0;
      seen_reg    <= 1'b0;
      err_reg     <= 1'b0;
      code_reg    <= 8'h00;
    end else begin
      state_reg   <= state_next;
      field_reg   <= field_next;
      filled_reg  <= filled_next;
      idx_reg     <= idx_next;
      nparams_reg <= nparams_next;
      ovf_reg     <= ovf_next;
      seen_reg    <= seen_next;
      err_reg     <= err_next;
      code_reg    <= code_next;
    end
  end

  assign cmd_valid   = (state_reg == HOLD);
  assign cmd_code    = code_reg;
  assign cmd_nparams = nparams_reg;
  assign cmd_ovf     = ovf_reg;
  assign err         = err_reg;

  for (genvar gi = 0; gi < MAX_PARAMS; gi++) begin : g_param
    assign cmd_params[gi*PARAM_W +: PARAM_W] = field_reg[gi];
  end

endmodule

// File: tb/tb_csi_param_decoder.sv
// Bench for csi_param_decoder: directed vectors plus random byte streams checked
// against a queue-based parser model that evaluates each command from its text.
module tb_csi_param_decoder;

  localparam int MAXP = 2;
  localparam int PW   = 8;
  localparam int DEFV = 1;
  localparam int SATV = 255;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_code;
  logic [1:0]  cmd_nparams;
  logic [15:0] cmd_params;
  logic        cmd_ovf;
  logic        err;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_mode;
  logic [7:0] m_q[$];
  int         exp_err, exp_cmd, exp_code, exp_np, exp_p0, exp_p1, exp_ovf;
  logic [7:0] seq[$];

  always #5 clk = ~clk;

  csi_param_decoder #(.MAX_PARAMS(MAXP), .PARAM_W(PW), .DEF_VAL(DEFV)) dut (
    .clk(clk), ._rst(rst_l), .in_valid(in_valid), .in(in_byte), .in_ready(in_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_nparams(cmd_nparams), .cmd_params(cmd_params), .cmd_ovf(cmd_ovf), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Evaluate a complete command from the collected parameter text.
  task automatic model_command(input logic [7:0] b);
    int acc[MAXP];
    int semis;
    int d;
    semis = 0;
    for (int i = 0; i < MAXP; i++) acc[i] = -1;
    foreach (m_q[k]) begin
      if (m_q[k] == 8'h3B) semis++;
      else if (semis < MAXP) begin
        d = int'(m_q[k]) - 48;
        acc[semis] = ((acc[semis] < 0) ? 0 : acc[semis]) * 10 + d;
        if (acc[semis] > SATV) acc[semis] = SATV;
      end
    end
    exp_code = int'(b);
    exp_np   = (m_q.size() == 0) ? 0 : ((semis + 1 < MAXP) ? semis + 1 : MAXP);
    exp_ovf  = (semis >= MAXP) ? 1 : 0;
    exp_p0   = (acc[0] < 0) ? DEFV : acc[0];
    exp_p1   = (acc[1] < 0) ? DEFV : acc[1];
  endtask

  task automatic model_step(input logic [7:0] b);
    exp_err = 0;
    exp_cmd = 0;
    case (m_mode)
      0: if (b == 8'h1B) m_mode = 1;
      1: begin
        if (b == 8'h5B) begin m_mode = 2; m_q.delete(); end
        else if (b == 8'h1B) m_mode = 1;
        else begin m_mode = 0; exp_err = 1; end
      end
      default: begin
        if ((b >= 8'h30 && b <= 8'h39) || b == 8'h3B) m_q.push_back(b);
        else if (b >= 8'h40 && b <= 8'h7E) begin model_command(b); exp_cmd = 1; m_mode = 0; end
        else if (b == 8'h1B) begin m_mode = 1; exp_err = 1; end
        else begin m_mode = 0; exp_err = 1; end
      end
    endcase
  endtask

  // One accepted byte; sampled 1 time unit after the capturing edge.
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_step(b);
    $display("byte=%02h err=%0b cmd_valid=%0b code=%02h np=%0d params=%04h ovf=%0b",
             b, err, cmd_valid, cmd_code, cmd_nparams, cmd_params, cmd_ovf);
    check("err", 32'(err), 32'(exp_err));
    check("cmd_valid", 32'(cmd_valid), 32'(exp_cmd));
    if (exp_cmd != 0) begin
      check("cmd_code", 32'(cmd_code), 32'(exp_code));
      check("cmd_nparams", 32'(cmd_nparams), 32'(exp_np));
      check("p0", 32'(cmd_params[7:0]), 32'(exp_p0));
      check("p1", 32'(cmd_params[15:8]), 32'(exp_p1));
      check("cmd_ovf", 32'(cmd_ovf), 32'(exp_ovf));
      check("in_ready_hold", 32'(in_ready), 32'(0));
    end else begin
      check("in_ready", 32'(in_ready), 32'(1));
    end
  endtask

  // Consume the held command after 'hold' cycles of backpressure with junk offered.
  task automatic release_cmd(input int hold);
    cmd_ready = (hold == 0);
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      check("hold_valid", 32'(cmd_valid), 32'(1));
      check("hold_in_ready", 32'(in_ready), 32'(0));
      check("hold_code", 32'(cmd_code), 32'(exp_code));
      check("hold_params", 32'(cmd_params), 32'((exp_p1 << 8) | exp_p0));
      check("hold_ovf", 32'(cmd_ovf), 32'(exp_ovf));
    end
    in_valid  = 1'b0;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", 32'(cmd_valid), 32'(0));
    check("release_in_ready", 32'(in_ready), 32'(1));
  endtask

  task automatic send_r(input logic [7:0] b);
    send(b);
    if (exp_cmd != 0) release_cmd($urandom_range(0, 3));
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_err", 32'(err), 32'(0));
    check("idle_valid", 32'(cmd_valid), 32'(0));
  endtask

  task automatic run_seq();
    foreach (seq[k]) send_r(seq[k]);
  endtask

  function automatic logic [7:0] rand_param_byte();
    if ($urandom_range(0, 9) < 8) return 8'(8'h30 + $urandom_range(0, 9));
    return 8'h3B;
  endfunction

  function automatic logic [7:0] rand_any();
    int r;
    r = $urandom_range(0, 99);
    if (r < 12) return 8'h1B;
    if (r < 22) return 8'h5B;
    if (r < 55) return 8'(8'h30 + $urandom_range(0, 9));
    if (r < 67) return 8'h3B;
    if (r < 82) return 8'($urandom_range(64, 126));
    return 8'($urandom_range(32, 47));
  endfunction

  initial begin
    m_mode    = 0;
    rst_l     = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    cmd_ready = 1'b1;
    #1 rst_l = 1'b0;
    #1;
    check("rst_valid", 32'(cmd_valid), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_code", 32'(cmd_code), 32'(0));
    check("rst_np", 32'(cmd_nparams), 32'(0));
    check("rst_params", 32'(cmd_params), 32'h0101);
    check("rst_ovf", 32'(cmd_ovf), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;

    // Basic two-field command with literal expectations.
    seq = {8'h1B, 8'h5B, 8'h31, 8'h32, 8'h3B, 8'h33, 8'h34};
    run_seq();
    send(8'h48);
    check("d1_code", 32'(cmd_code), 32'h48);
    check("d1_np", 32'(cmd_nparams), 32'(2));
    check("d1_params", 32'(cmd_params), 32'h220C);
    check("d1_ovf", 32'(cmd_ovf), 32'(0));
    release_cmd(0);

    seq = {8'h1B, 8'h5B};
    run_seq();
    send(8'h41);
    check("d2_np", 32'(cmd_nparams), 32'(0));
    check("d2_params", 32'(cmd_params), 32'h0101);
    release_cmd(0);

    seq = {8'h1B, 8'h5B, 8'h3B, 8'h35};
    run_seq();
    send(8'h48);
    check("d3_np", 32'(cmd_nparams), 32'(2));
    check("d3_params", 32'(cmd_params), 32'h0501);
    release_cmd(0);

    seq = {8'h1B, 8'h5B, 8'h33, 8'h30, 8'h30};
    run_seq();
    send(8'h43);
    check("d4_sat", 32'(cmd_params[7:0]), 32'(255));
    check("d4_np", 32'(cmd_nparams), 32'(1));
    release_cmd(0);

    seq = {8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h32, 8'h3B, 8'h33};
    run_seq();
    send(8'h6D);
    check("d5_params", 32'(cmd_params), 32'h0201);
    check("d5_ovf", 32'(cmd_ovf), 32'(1));
    check("d5_np", 32'(cmd_nparams), 32'(2));
    release_cmd(0);

    seq = {8'h1B, 8'h5B, 8'h35};
    run_seq();
    send(8'h1B);
    check("d6_err", 32'(err), 32'(1));
    seq = {8'h5B, 8'h37};
    run_seq();
    check("d6_err_once", 32'(err), 32'(0));
    send(8'h44);
    check("d6_code", 32'(cmd_code), 32'h44);
    check("d6_p0", 32'(cmd_params[7:0]), 32'(7));
    release_cmd(3);

    seq = {8'h1B, 8'h5B, 8'h35, 8'h20};
    run_seq();
    check("d7_err", 32'(err), 32'(1));
    idle_cycle();
    idle_cycle();

    // Reset while holding a command: cmd_valid must drop before any clock edge.
    seq = {8'h1B, 8'h5B, 8'h39};
    run_seq();
    send(8'h48);
    cmd_ready = 1'b0;
    #3 rst_l = 1'b0;
    #1;
    check("arst_valid", 32'(cmd_valid), 32'(0));
    check("arst_in_ready", 32'(in_ready), 32'(1));
    check("arst_params", 32'(cmd_params), 32'h0101);
    check("arst_code", 32'(cmd_code), 32'(0));
    #10 rst_l = 1'b1;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    m_mode = 0;
    repeat (3) idle_cycle();

    // Reset mid-sequence discards it; trailing digit+final alone issue nothing.
    seq = {8'h1B, 8'h5B, 8'h32};
    run_seq();
    #3 rst_l = 1'b0;
    #10 rst_l = 1'b1;
    @(posedge clk); #1;
    m_mode = 0;
    seq = {8'h33, 8'h44};
    run_seq();
    idle_cycle();

    // Random streams.
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 3) == 0) send_r(rand_any());
      send_r(8'h1B);
      send_r(8'h5B);
      for (int n = $urandom_range(0, 7); n > 0; n--) begin
        if ($urandom_range(0, 9) == 0 && m_mode != 2) idle_cycle();
        else if ($urandom_range(0, 9) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
          check("gap_err", 32'(err), 32'(0));
        end
        send_r(rand_param_byte());
      end
      if ($urandom_range(0, 3) != 0) send_r(8'($urandom_range(64, 126)));
      else send_r(rand_any());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csi_param_decoder.md
CSI_PARAM_DECODER -- requirements
Module: csi_param_decoder

Interface
REQ-001 Parameter MAX_PARAMS, default 2, maximum number of numeric fields captured per sequence (>=1).
REQ-002 Parameter PARAM_W, default 8, width of each numeric field.
REQ-003 Parameter DEF_VAL, default 1, value reported for empty or absent fields.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 _rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  input byte present.
REQ-007 in  input  8  input byte (ASCII).
REQ-008 in_ready  output  1  decoder accepts a byte this cycle.
REQ-009 cmd_valid  output  1  decoded command available.
REQ-010 cmd_ready  input  1  consumer takes the command.
REQ-011 cmd_code  output  8  CSI final byte.
REQ-012 cmd_nparams  output  $clog2(MAX_PARAMS+1)  number of fields reported.
REQ-013 cmd_params  output  MAX_PARAMS*PARAM_W  field i at bits [i*PARAM_W +: PARAM_W].
REQ-014 cmd_ovf  output  1  more than MAX_PARAMS fields were received.
REQ-015 err  output  1  one-cycle pulse on a malformed sequence.

Function
REQ-016 A byte SHALL be accepted only when in_valid and in_ready are both 1; in_ready SHALL be 1 in every state except HOLD.
REQ-017 FSM states SHALL be IDLE, ESC, PARAM, and HOLD.
REQ-018 IDLE: accepted 0x1B -> ESC; any other accepted byte -> IDLE, with no err.
REQ-019 ESC: 0x5B -> PARAM, with all fields set to DEF_VAL, field index 0, ovf 0, and the seen flag cleared; 0x1B -> ESC; any other byte -> IDLE with err pulse.
REQ-020 PARAM, digit 0x30-0x39: field = field*10 + digit, saturating at 2^PARAM_W-1; the field is marked non-empty; seen = 1.
REQ-021 A non-empty field's accumulation SHALL start from 0, not from DEF_VAL.
REQ-022 PARAM, 0x3B (';'): seen = 1; if index < MAX_PARAMS-1, index increments; otherwise ovf = 1 and subsequent digits are discarded.
REQ-023 PARAM, final byte 0x40-0x7E -> HOLD; cmd_code = byte; cmd_nparams = seen ? min(index+1, MAX_PARAMS) : 0.
REQ-024 PARAM, 0x1B -> ESC with err pulse (sequence restart).
REQ-025 PARAM, any other byte -> IDLE with err pulse; no command is issued.
REQ-026 HOLD: cmd_valid = 1; cmd_code, cmd_nparams, cmd_params, and cmd_ovf SHALL be stable; in_ready = 0; cmd_ready = 1 -> IDLE.
REQ-027 cmd_valid SHALL rise the cycle after the final byte is accepted (latency 1) and fall the cycle after the cmd_ready handshake.
REQ-028 Fields not received SHALL read DEF_VAL; empty fields (e.g. ";;") SHALL read DEF_VAL.
REQ-029 While in_valid is 0, state and accumulators SHALL hold.
REQ-030 err SHALL be registered, high for exactly one cycle per error, and SHALL not coincide with cmd_valid rising.

Reset
REQ-031 _rst low SHALL immediately force IDLE, independent of clk.
REQ-032 During reset: cmd_valid = 0, err = 0, cmd_code = 0, cmd_nparams = 0, cmd_params all DEF_VAL, cmd_ovf = 0, in_ready = 1.
REQ-033 Reset asserted mid-sequence or in HOLD SHALL discard the pending sequence or command; no cmd_valid SHALL follow reset release.

Verification (MAX_PARAMS=2, PARAM_W=8, DEF_VAL=1, cmd_ready=1 unless stated)
REQ-034 Stimulus 1B 5B 31 32 3B 33 34 48 -> next cycle cmd_valid=1, cmd_code=0x48, nparams=2, p0=12, p1=34, ovf=0.
REQ-035 Stimulus 1B 5B 41 -> cmd_code=0x41, nparams=0, p0=1, p1=1; stimulus 1B 5B 3B 35 48 -> nparams=2, p0=1, p1=5.
REQ-036 Stimulus 1B 5B 33 30 30 43 -> p0=255 (saturated), nparams=1.
REQ-037 Stimulus 1B 5B 31 3B 32 3B 33 6D -> nparams=2, p0=1, p1=2, ovf=1.
REQ-038 Stimulus 1B 5B 35 1B 5B 37 44 -> a single err pulse on the second 1B, then cmd_code=0x44, p0=7; stimulus 1B 5B 35 20 -> err pulse, no cmd_valid.
REQ-039 Backpressure: hold cmd_ready=0 for 3 cycles after a command while driving in_valid=1 with bytes -> cmd_valid stays 1, outputs stable, in_ready=0, bytes ignored; assert _rst in HOLD -> cmd_valid=0 with no clk edge.
